// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and default sizing for the data-memory arbiter slice.
//   arb_state_t : arbiter ownership state (IDLE, OWN0, OWN1)
//   port_id_t   : requester index, 0 = core load/store, 1 = bulk-copy/debug
//   DMEM_*      : default address width, data width and locked-burst length
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W    = 10;
    localparam int DMEM_DATA_W    = 32;
    localparam int DMEM_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
// Combinational two-way picker used while the arbiter is idle.
// A single valid port always wins; a tie is resolved by the tie policy.
// Build option: DMEM_ARB_RR_EN defined -> round-robin ties (go to the port
// that was not granted last); undefined -> fixed priority to port 0, except
// right after a forced end of a locked burst, when the tie goes to the
// other port.
// Ports:
//   valid[1:0]  : per-port request
//   last        : most recently granted port
//   force_other : previous tenure ended by hitting the burst limit
//   grant[1:0]  : one-hot grant (all zero when nothing is valid)
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic     [1:0] valid,
    input  port_id_t       last,
    input  logic           force_other,
    output logic     [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
    localparam logic RR_TIES = 1'b1;
`else
    localparam logic RR_TIES = 1'b0;
`endif

    port_id_t tie_winner;

    always_comb begin
        tie_winner = (RR_TIES || force_other) ? port_id_t'(~last) : PORT0;
        grant      = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (tie_winner == PORT1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-ported data memory between the core port (p0) and the
// bulk-copy/debug port (p1). Each accepted beat drives one memory access at
// address (base + offset) mod 2^ADDR_W; load data returns one cycle later.
// A requester holding lock keeps ownership for up to MAX_BURST beats.
// Build option: DMEM_ARB_RR_EN selects round-robin ties (see dmem_arb_pick).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; picker chooses among valid ports
// OWN0  | port 0 holds a locked burst; only p0 may be accepted
// OWN1  | port 1 holds a locked burst; only p1 may be accepted
//
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   pN_valid/ready              : beat handshake (accept = valid & ready)
//   pN_we, pN_lock              : store select, keep ownership after beat
//   pN_base, pN_offset          : address operands (low ADDR_W bits used)
//   pN_wdata                    : store data
//   pN_rvalid, pN_rdata         : load response, one cycle after accept
//   mem_en/we/addr/wdata        : memory command (zero when idle)
//   mem_rdata                   : memory read data, one cycle after mem_en
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int MAX_BURST = DMEM_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [31:0]       p0_base,
    input  logic [15:0]       p0_offset,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [31:0]       p1_base,
    input  logic [15:0]       p1_offset,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    port_id_t         last;
    logic             force_other;
    logic             rvalid0_q;
    logic             rvalid1_q;
    logic [1:0]       grant;
    logic             acc0;
    logic             acc1;
    logic             sel_lock;

    // Only the low ADDR_W bits of the address operands take part.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_base[31:ADDR_W], p0_offset[15:ADDR_W],
                                p1_base[31:ADDR_W], p1_offset[15:ADDR_W]};

    dmem_arb_pick u_pick (
        .valid       ({p1_valid, p0_valid}),
        .last        (last),
        .force_other (force_other),
        .grant       (grant)
    );

    // Ready is only ever raised for a valid port, so ready alone marks a beat.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    p0_ready = grant[0];
                    p1_ready = grant[1];
                end
                OWN0:    p0_ready = p0_valid;
                OWN1:    p1_ready = p1_valid;
                default: ;
            endcase
        end
    end

    assign acc0    = p0_ready;
    assign acc1    = p1_ready;
    assign cnt_inc = cnt + CNT_ONE;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        sel_lock  = 1'b0;
        if (acc0) begin
            mem_en    = 1'b1;
            mem_we    = p0_we;
            mem_addr  = p0_base[ADDR_W-1:0] + p0_offset[ADDR_W-1:0];
            mem_wdata = p0_wdata;
            sel_lock  = p0_lock;
        end else if (acc1) begin
            mem_en    = 1'b1;
            mem_we    = p1_we;
            mem_addr  = p1_base[ADDR_W-1:0] + p1_offset[ADDR_W-1:0];
            mem_wdata = p1_wdata;
            sel_lock  = p1_lock;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= PORT1;
            force_other <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            rvalid0_q <= acc0 & ~p0_we;
            rvalid1_q <= acc1 & ~p1_we;
            if (acc0 || acc1) begin
                last <= acc1 ? PORT1 : PORT0;
                if (sel_lock && (cnt_inc < CNT_MAX)) begin
                    state       <= acc1 ? OWN1 : OWN0;
                    cnt         <= cnt_inc;
                    force_other <= 1'b0;
                end else begin
                    state       <= IDLE;
                    cnt         <= '0;
                    // Still asking for lock here means the burst limit cut
                    // the tenure short, so the next tie must hand over.
                    force_other <= sel_lock;
                end
            end else if (state != IDLE) begin
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end

    // Gating with reset drops a response that was in flight when reset hit.
    assign p0_rvalid = rvalid0_q & ~reset;
    assign p1_rvalid = rvalid1_q & ~reset;
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_ready, p0_we, p0_lock, p0_rvalid;
    logic [31:0] p0_base, p0_wdata, p0_rdata;
    logic [15:0] p0_offset;
    logic        p1_valid, p1_ready, p1_we, p1_lock, p1_rvalid;
    logic [31:0] p1_base, p1_wdata, p1_rdata;
    logic [15:0] p1_offset;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_arr [1024];
    bit          wr_flag [1024];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_we     (p0_we),
        .p0_lock   (p0_lock),
        .p0_base   (p0_base),
        .p0_offset (p0_offset),
        .p0_wdata  (p0_wdata),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_we     (p1_we),
        .p1_lock   (p1_lock),
        .p1_base   (p1_base),
        .p1_offset (p1_offset),
        .p1_wdata  (p1_wdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous memory; unwritten words read back as 0xA500_0000 | addr.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            wr_flag[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= wr_flag[mem_addr] ? mem_arr[mem_addr]
                                           : (32'hA500_0000 | 32'(mem_addr));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_p0(input logic v, input logic we, input logic lk,
                            input logic [31:0] base, input logic [15:0] off,
                            input logic [31:0] wd);
        p0_valid = v; p0_we = we; p0_lock = lk;
        p0_base = base; p0_offset = off; p0_wdata = wd;
    endtask

    task automatic drive_p1(input logic v, input logic we, input logic lk,
                            input logic [31:0] base, input logic [15:0] off,
                            input logic [31:0] wd);
        p1_valid = v; p1_we = we; p1_lock = lk;
        p1_base = base; p1_offset = off; p1_wdata = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          g;
        logic [31:0] exp_addr;

        reset = 1'b1;
        drive_p0(1, 0, 0, 0, 0, 0);
        drive_p1(1, 0, 0, 0, 0, 0);
        next_cycle();
        chk("rst_p0_ready", 32'(p0_ready), 0);
        chk("rst_p1_ready", 32'(p1_ready), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        next_cycle();
        reset = 1'b0;

        // basic p0 load: 0x10 + 5 = 21
        drive_p1(0, 0, 0, 0, 0, 0);
        drive_p0(1, 0, 0, 32'h10, 16'd5, 0);
        #1;
        chk("ld_p0_ready", 32'(p0_ready), 1);
        chk("ld_p1_ready", 32'(p1_ready), 0);
        chk("ld_mem_en", 32'(mem_en), 1);
        chk("ld_mem_we", 32'(mem_we), 0);
        chk("ld_mem_addr", 32'(mem_addr), 21);
        next_cycle();
        drive_p0(0, 0, 0, 0, 0, 0);
        #1;
        chk("ld_p0_rvalid", 32'(p0_rvalid), 1);
        chk("ld_p0_rdata", p0_rdata, 32'hA500_0015);
        chk("ld_p1_rvalid", 32'(p1_rvalid), 0);
        chk("idle_mem_en", 32'(mem_en), 0);
        chk("idle_mem_addr", 32'(mem_addr), 0);

        // wrapped store 1020 + 8 -> 4, then load it back
        drive_p1(1, 1, 0, 32'd1020, 16'd8, 32'hDEAD_BEEF);
        #1;
        chk("wr_p1_ready", 32'(p1_ready), 1);
        chk("wr_mem_addr", 32'(mem_addr), 4);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        drive_p1(1, 0, 0, 0, 16'd4, 0);
        #1;
        chk("rb_mem_addr", 32'(mem_addr), 4);
        chk("rb_mem_we", 32'(mem_we), 0);
        chk("st_no_rvalid", 32'(p1_rvalid), 0);
        next_cycle();
        drive_p1(0, 0, 0, 0, 0, 0);
        #1;
        chk("rb_p1_rvalid", 32'(p1_rvalid), 1);
        chk("rb_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
        chk("rb_p0_rvalid", 32'(p0_rvalid), 0);

        // both valid, no lock: RR alternates starting at 0, fixed always 0
        for (int k = 0; k < 4; k++) begin
            g = RR_MODE ? (k % 2 == 1) : 1'b0;
            exp_addr = g ? 32'(64 + k) : 32'(32 + k);
            drive_p0(1, 0, 0, 0, 16'(32 + k), 0);
            drive_p1(1, 0, 0, 0, 16'(64 + k), 0);
            #1;
            chk("tie_p0_ready", 32'(p0_ready), 32'(!g));
            chk("tie_p1_ready", 32'(p1_ready), 32'(g));
            chk("tie_mem_addr", 32'(mem_addr), exp_addr);
            next_cycle();
            chk("tie_p0_rvalid", 32'(p0_rvalid), 32'(!g));
            chk("tie_p1_rvalid", 32'(p1_rvalid), 32'(g));
            chk("tie_rdata", g ? p1_rdata : p0_rdata, 32'hA500_0000 | exp_addr);
        end

        // p1 locked burst of MAX_BURST=4 while p0 waits, then p0 gets a beat
        for (int k = 0; k < 4; k++) begin
            drive_p1(1, 0, 1, 32'd100, 16'(k), 0);
            drive_p0(k > 0, 0, 0, 0, 16'd200, 0);
            #1;
            chk("b1_p1_ready", 32'(p1_ready), 1);
            chk("b1_p0_ready", 32'(p0_ready), 0);
            chk("b1_mem_addr", 32'(mem_addr), 32'(100 + k));
            next_cycle();
        end
        drive_p1(1, 0, 1, 32'd100, 16'd4, 0);
        #1;
        chk("b1_hand_p0", 32'(p0_ready), 1);
        chk("b1_hand_p1", 32'(p1_ready), 0);
        chk("b1_hand_addr", 32'(mem_addr), 200);
        next_cycle();

        // p0 locked burst of 4 stores while p1 waits, then p1 must win the tie
        for (int k = 0; k < 4; k++) begin
            drive_p0(1, 1, 1, 0, 16'(300 + k), 32'(k));
            drive_p1(k > 0, 0, 0, 0, 16'd400, 0);
            #1;
            chk("b0_p0_ready", 32'(p0_ready), 1);
            chk("b0_p1_ready", 32'(p1_ready), 0);
            next_cycle();
        end
        drive_p0(1, 0, 0, 0, 16'd310, 0);
        #1;
        chk("b0_hand_p1", 32'(p1_ready), 1);
        chk("b0_hand_p0", 32'(p0_ready), 0);
        chk("b0_hand_addr", 32'(mem_addr), 400);
        next_cycle();

        // p0 locked, drops valid after two beats: one dead cycle, then p1
        drive_p1(0, 0, 0, 0, 0, 0);
        drive_p0(1, 0, 1, 0, 16'd500, 0);
        #1;
        chk("drop_b1_p0", 32'(p0_ready), 1);
        next_cycle();
        drive_p1(1, 0, 0, 0, 16'd600, 0);
        #1;
        chk("drop_b2_p0", 32'(p0_ready), 1);
        chk("drop_b2_p1", 32'(p1_ready), 0);
        next_cycle();
        drive_p0(0, 0, 0, 0, 0, 0);
        #1;
        chk("drop_gap_p1", 32'(p1_ready), 0);
        chk("drop_gap_en", 32'(mem_en), 0);
        next_cycle();
        #1;
        chk("drop_next_p1", 32'(p1_ready), 1);
        chk("drop_next_addr", 32'(mem_addr), 600);
        next_cycle();

        // reset right after a locked p0 load
        drive_p1(0, 0, 0, 0, 0, 0);
        drive_p0(1, 0, 1, 0, 16'd21, 0);
        #1;
        chk("mr_p0_ready", 32'(p0_ready), 1);
        next_cycle();
        reset = 1'b1;
        drive_p1(1, 0, 0, 0, 16'd700, 0);
        #1;
        chk("mr_p0_ready_rst", 32'(p0_ready), 0);
        chk("mr_p1_ready_rst", 32'(p1_ready), 0);
        chk("mr_mem_en_rst", 32'(mem_en), 0);
        chk("mr_p0_rvalid", 32'(p0_rvalid), 0);
        chk("mr_p0_rdata", p0_rdata, 0);
        next_cycle();
        reset = 1'b0;
        drive_p0(0, 0, 0, 0, 0, 0);
        #1;
        chk("mr_idle_p1", 32'(p1_ready), 1);
        chk("mr_idle_addr", 32'(mem_addr), 700);
        chk("mr_p0_rvalid2", 32'(p0_rvalid), 0);
        next_cycle();
        drive_p1(0, 0, 0, 0, 0, 0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported 1024×32 data memory. It shares the memory between the core load/store port (port 0) and the bulk-copy/debug port (port 1). It forms each effective address as base + offset, issues one memory beat per cycle and returns read data one cycle later. Requesters can hold the memory for short locked bursts, which bulk initialisation and multi-word copies use.

## Interface
- ADDR_W, 10, memory word-address width (1024 words)
- DATA_W, 32, data width
- MAX_BURST, 4, maximum beats per locked tenure (≥1)

Ports, listed once with N ∈ {0,1}:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pN_valid  in  1  beat request
- pN_ready  out  1  beat accepted this cycle when valid&ready
- pN_we  in  1  1 = store, 0 = load
- pN_lock  in  1  request to keep ownership after this beat
- pN_base  in  32  base address; only [ADDR_W-1:0] used
- pN_offset  in  16  offset; only [ADDR_W-1:0] used
- pN_wdata  in  DATA_W  store data
- pN_rvalid  out  1  load data valid
- pN_rdata  out  DATA_W  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en & !mem_we

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, burst count cnt (0..MAX_BURST), rr pointer last, pending-read flags.
- IDLE: the picker chooses among valid ports. A single valid port wins. A tie is resolved by the pointer (see Configuration). pN_ready=1 for the winner only.
- OWNn: only port n can get ready, and pN_ready=pN_valid. The other port's ready is 0 even if it is valid.
- Accepted beat: mem_en=1, mem_we=pN_we, mem_wdata=pN_wdata, mem_addr=(pN_base[ADDR_W-1:0]+pN_offset[ADDR_W-1:0]) mod 2^ADDR_W. Wrap-around is silent, e.g. 1020+8 → 4.
- Transitions after an accepted beat by port n:
  - lock=1 and cnt+1 < MAX_BURST → OWNn, cnt+1.
  - Otherwise → IDLE, cnt=0.
- In OWNn, if pN_valid=0 → IDLE next cycle, cnt=0, with no beat.
- Forced release at MAX_BURST: the next tie must go to the other port, in both configurations.
- Loads: one cycle after an accepted load by port n, pN_rvalid=1 and pN_rdata=mem_rdata. The other port's rvalid stays 0.
- Stores: produce no response.
- No mem_en without an accepted beat. mem_* outputs are 0 when idle.

## Timing
- pN_ready and mem_* are combinational from valid, state and pointer. This gives a zero-cycle accept.
- Load latency is exactly 1 cycle from acceptance to rvalid. The throughput is 1 beat per cycle, sustained across port switches.
- Store in cycle t followed by a load of the same address in cycle t+1 returns the stored value at t+2.
- Reset values: state=IDLE, cnt=0, last=1, pN_rvalid=0, pN_rdata=0. While reset=1, pN_ready=0 and mem_en=0.
- Reset mid-burst: the next cycle is IDLE, and the pending load response is dropped (rvalid=0).

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. last holds the most recently granted port, and a tie goes to the other port. last updates on every accepted beat.
- Not defined: fixed priority, and a tie goes to port 0. last is still kept, but only to implement the post-MAX_BURST handoff rule.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, OWN0, OWN1), port-id typedef, default ADDR_W/DATA_W/MAX_BURST constants.
- Sub-module dmem_arb_pick: combinational two-way picker with inputs valid[1:0], last and force_other, and output grant one-hot. It holds the DMEM_ARB_RR_EN selection.

## Test plan
- After reset, p0 load base=0x10, offset=5 → mem_addr=21, mem_we=0. p0_rvalid=1 one cycle later with rdata=mem_rdata. p1_rvalid=0.
- Wrap: p1 store base=1020, offset=8, wdata=0xDEADBEEF → mem_addr=4, mem_we=1. Load of addr 4 next cycle returns 0xDEADBEEF.
- Both valid every cycle, lock=0, RR_EN defined → grants alternate 0,1,0,1. With RR_EN undefined → port 0 every cycle, port 1 starved.
- p1 lock=1 with MAX_BURST=4 while p0 is valid → p1 gets 4 consecutive beats, then p0 gets the next beat in both configurations.
- p0 locked, drops valid after 2 beats → IDLE next cycle. A p1 request is then accepted, with no lost cycle beyond that one.
- reset asserted in the cycle after an accepted p0 load → p0_rvalid=0, state IDLE, all readys 0 during reset.
